// File: rtl/display_scan_driver_pkg.sv
// Shared definitions for the display scan driver.
//
// Holds the hex-to-segment constants (active-high form, bit order {a,b,c,d,e,f,g})
// and a width helper used to size the digit index and slot counter.
// No ports; imported by display_scan_driver and seg7_hex_decoder.

package display_scan_driver_pkg;

    localparam logic [6:0] SEG_0   = 7'h7E;
    localparam logic [6:0] SEG_1   = 7'h30;
    localparam logic [6:0] SEG_2   = 7'h6D;
    localparam logic [6:0] SEG_3   = 7'h79;
    localparam logic [6:0] SEG_4   = 7'h33;
    localparam logic [6:0] SEG_5   = 7'h5B;
    localparam logic [6:0] SEG_6   = 7'h5F;
    localparam logic [6:0] SEG_7   = 7'h70;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h7B;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h1F;  // lower-case b
    localparam logic [6:0] SEG_C   = 7'h4E;
    localparam logic [6:0] SEG_D   = 7'h3D;  // lower-case d
    localparam logic [6:0] SEG_E   = 7'h4F;
    localparam logic [6:0] SEG_F   = 7'h47;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Bits needed to count 0..n-1; never less than 1 so a single-digit
    // build still gets a real (if constant) index register.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-seven-segment decoder.
//
// Ports:
//   code   in  4  hex code 0..F
//   blank  in  1  1 = all segments off
//   seg    out 7  {a,b,c,d,e,f,g}, active-high (1 = segment lit)

module seg7_hex_decoder
    import display_scan_driver_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (code)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                4'hF: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed driver for DIGITS seven-segment digits on a shared segment bus.
// Scans one digit per REFRESH_DIV-clock slot, keeps every digit dark for the first
// DEAD_CYCLES clocks of its slot, and double-buffers the display data so a frame
// only ever shows one consistent set of values.
//
// Optional feature macro: DISPLAY_BLINK_EN (adds blink_mask input and BLINK_FRAMES).
//
// Ports:
//   clk         in   1         system clock
//   reset       in   1         synchronous, active-high reset
//   load        in   1         capture value/blank_mask/dp_mask into the pending buffer
//   value       in   4*DIGITS  hex code per digit, digit0 = value[3:0]
//   blank_mask  in   DIGITS    1 = digit blanked (segments and dp off)
//   dp_mask     in   DIGITS    1 = decimal point lit
//   blink_mask  in   DIGITS    (DISPLAY_BLINK_EN only) digits that blink
//   seg         out  7         {a,b,c,d,e,f,g}, polarity per ACTIVE_LOW_SEG
//   seg_dp      out  1         decimal point, polarity per ACTIVE_LOW_SEG
//   digit_en    out  DIGITS    one-hot digit select, polarity per ACTIVE_LOW_DIG
//   frame_done  out  1         1-cycle pulse when the scan wraps to digit 0

module display_scan_driver
    import display_scan_driver_pkg::*;
#(
`ifdef DISPLAY_BLINK_EN
    parameter int BLINK_FRAMES   = 64,
`endif
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DEAD_CYCLES    = 2,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_DIG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     dp_mask,
`ifdef DISPLAY_BLINK_EN
    input  logic [DIGITS-1:0]     blink_mask,
`endif
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int IDX_W = width_of(DIGITS);
    localparam int CNT_W = width_of(REFRESH_DIV);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DEAD = CNT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [6:0]        SEG_OFF_LVL = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF_LVL  = (ACTIVE_LOW_SEG != 0);
    localparam logic [DIGITS-1:0] DIG_OFF_LVL = (ACTIVE_LOW_DIG != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                wrap;

    logic [4*DIGITS-1:0] pend_value, act_value;
    logic [DIGITS-1:0]   pend_blank, act_blank;
    logic [DIGITS-1:0]   pend_dp, act_dp;
    logic                pending;

    logic [DIGITS-1:0]   eff_blank;
    logic [3:0]          cur_code;
    logic                cur_blank;
    logic                cur_dp;
    logic [DIGITS-1:0]   onehot;
    logic [6:0]          seg_hi;

    assign wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Slot counter and digit index; idx only moves at the end of a slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer. A load that lands exactly on the wrap goes straight to the
    // active copy, otherwise the new frame would be delayed by a full scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_value <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            act_value  <= '0;
            act_blank  <= '0;
            act_dp     <= '0;
        end else if (load && wrap) begin
            act_value  <= value;
            act_blank  <= blank_mask;
            act_dp     <= dp_mask;
            pending    <= 1'b0;
        end else if (load) begin
            pend_value <= value;
            pend_blank <= blank_mask;
            pend_dp    <= dp_mask;
            pending    <= 1'b1;
        end else if (wrap && pending) begin
            act_value  <= pend_value;
            act_blank  <= pend_blank;
            act_dp     <= pend_dp;
            pending    <= 1'b0;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BLK_W = width_of(BLINK_FRAMES);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    // Phase 0 is the lit half; it flips after every BLINK_FRAMES frame wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + 1'b1;
            end
        end
    end

    assign eff_blank = act_blank | (blink_phase ? blink_mask : {DIGITS{1'b0}});
`else
    assign eff_blank = act_blank;
`endif

    // Pick the active digit's data; compare-per-digit keeps every select constant.
    always_comb begin
        cur_code  = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        onehot    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_code  = act_value[4*i +: 4];
                cur_blank = eff_blank[i];
                cur_dp    = act_dp[i];
                onehot[i] = 1'b1;
            end
        end
    end

    seg7_hex_decoder u_decoder (
        .code  (cur_code),
        .blank (cur_blank),
        .seg   (seg_hi)
    );

    // Output registers; polarity is applied here and nowhere else. Segments carry
    // the digit for the whole slot, the enable only after the dead time.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_OFF_LVL;
            seg_dp     <= DP_OFF_LVL;
            digit_en   <= DIG_OFF_LVL;
            frame_done <= 1'b0;
        end else begin
            seg        <= (ACTIVE_LOW_SEG != 0) ? ~seg_hi : seg_hi;
            seg_dp     <= (ACTIVE_LOW_SEG != 0) ? ~(cur_dp & ~cur_blank) : (cur_dp & ~cur_blank);
            if (cnt >= CNT_DEAD)
                digit_en <= (ACTIVE_LOW_DIG != 0) ? ~onehot : onehot;
            else
                digit_en <= DIG_OFF_LVL;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed testbench for display_scan_driver with DIGITS=4, REFRESH_DIV=8,
// DEAD_CYCLES=2, active-low segments and digits. cyc counts rising edges since
// reset was released; outputs seen after edge k describe slot position k-1,
// so slot s cnt c appears at cyc = 8*s + c + 1 within a 32-cycle frame.

module tb_display_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  dp_mask;
`ifdef DISPLAY_BLINK_EN
    logic [3:0]  blink_mask;
`endif
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  digit_en;
    logic        frame_done;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    display_scan_driver #(
`ifdef DISPLAY_BLINK_EN
        .BLINK_FRAMES   (2),
`endif
        .DIGITS         (4),
        .REFRESH_DIV    (8),
        .DEAD_CYCLES    (2),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_DIG (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
`ifdef DISPLAY_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .seg        (seg),
        .seg_dp     (seg_dp),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic runTo(input int n);
        while (cyc < n) step();
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm);
        load       = 1'b1;
        value      = v;
        blank_mask = bm;
        dp_mask    = dm;
        step();
        load       = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] e_seg, input logic e_dp,
                               input logic [3:0] e_en, input logic e_fd);
        vectors++;
        assert (seg === e_seg) else begin
            miscompares++;
            $error("[TB] FAIL %s seg got %b want %b (cyc %0d)", tag, seg, e_seg, cyc);
        end
        vectors++;
        assert (seg_dp === e_dp) else begin
            miscompares++;
            $error("[TB] FAIL %s seg_dp got %b want %b (cyc %0d)", tag, seg_dp, e_dp, cyc);
        end
        vectors++;
        assert (digit_en === e_en) else begin
            miscompares++;
            $error("[TB] FAIL %s digit_en got %b want %b (cyc %0d)", tag, digit_en, e_en, cyc);
        end
        vectors++;
        assert (frame_done === e_fd) else begin
            miscompares++;
            $error("[TB] FAIL %s frame_done got %b want %b (cyc %0d)", tag, frame_done, e_fd, cyc);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        value      = 16'h0000;
        blank_mask = 4'b0000;
        dp_mask    = 4'b0000;
`ifdef DISPLAY_BLINK_EN
        blink_mask = 4'b0000;
`endif

        // Reset held for three edges, then released
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset", 7'h7F, 1'b1, 4'hF, 1'b0);
        reset = 1'b0;
        cyc   = 0;

        runTo(1);  checkOutput("post_reset_c1", 7'h01, 1'b1, 4'hF,    1'b0);
        runTo(2);  checkOutput("post_reset_c2", 7'h01, 1'b1, 4'hF,    1'b0);
        runTo(3);  checkOutput("first_enable",  7'h01, 1'b1, 4'b1110, 1'b0);

        // Load 1234 mid-frame; it must wait for the wrap
        applyStimulus(16'h1234, 4'b0000, 4'b0000);
        runTo(30); checkOutput("old_frame_d3",  7'h01, 1'b1, 4'b0111, 1'b0);
        runTo(31); checkOutput("pre_wrap",      7'h01, 1'b1, 4'b0111, 1'b0);
        runTo(32); checkOutput("wrap1",         7'h01, 1'b1, 4'b0111, 1'b1);
        runTo(33); checkOutput("slot0_dead",    7'b1001100, 1'b1, 4'hF, 1'b0);
        runTo(35); checkOutput("slot0_on",      7'b1001100, 1'b1, 4'b1110, 1'b0);

        // Dead time and strobe length in slot 1, then the remaining digits
        runTo(41); checkOutput("slot1_dead0",   7'h06, 1'b1, 4'hF,    1'b0);
        runTo(42); checkOutput("slot1_dead1",   7'h06, 1'b1, 4'hF,    1'b0);
        runTo(43); checkOutput("slot1_on0",     7'h06, 1'b1, 4'b1101, 1'b0);
        runTo(48); checkOutput("slot1_on5",     7'h06, 1'b1, 4'b1101, 1'b0);
        runTo(49); checkOutput("slot2_dead0",   7'h12, 1'b1, 4'hF,    1'b0);
        runTo(54); checkOutput("slot2_on",      7'h12, 1'b1, 4'b1011, 1'b0);
        runTo(60); checkOutput("slot3_on",      7'b1001111, 1'b1, 4'b0111, 1'b0);
        runTo(63); checkOutput("pre_wrap2",     7'b1001111, 1'b1, 4'b0111, 1'b0);
        runTo(64); checkOutput("wrap2",         7'b1001111, 1'b1, 4'b0111, 1'b1);

        // ABCD then 0000 on consecutive cycles; only 0000 ever shows
        runTo(69);
        applyStimulus(16'hABCD, 4'b0000, 4'b0000);
        applyStimulus(16'h0000, 4'b0000, 4'b0000);
        runTo(80); checkOutput("hold_1234_d1",  7'h06, 1'b1, 4'b1101, 1'b0);
        runTo(95); checkOutput("hold_1234_d3",  7'b1001111, 1'b1, 4'b0111, 1'b0);
        runTo(97); checkOutput("new0_dead",     7'h01, 1'b1, 4'hF,    1'b0);
        runTo(99); checkOutput("new0_d0",       7'h01, 1'b1, 4'b1110, 1'b0);
        runTo(125); checkOutput("new0_d3",      7'h01, 1'b1, 4'b0111, 1'b0);

        // Load on the wrap edge goes straight to slot 0
        runTo(127);
        applyStimulus(16'h5678, 4'b0000, 4'b0000);
        checkOutput("wrap_load_edge",          7'h01, 1'b1, 4'b0111, 1'b1);
        runTo(129); checkOutput("bypass_dead",  7'h00, 1'b1, 4'hF,    1'b0);
        runTo(131); checkOutput("bypass_d0",    7'h00, 1'b1, 4'b1110, 1'b0);
        runTo(155); checkOutput("bypass_d3",    7'h24, 1'b1, 4'b0111, 1'b0);

        // Blank digit 3, decimal points on digits 0 and 3
        runTo(139);
        applyStimulus(16'h5678, 4'b1000, 4'b1001);
        runTo(163); checkOutput("dp_d0",        7'h00, 1'b0, 4'b1110, 1'b0);
        runTo(187); checkOutput("blank_d3",     7'h7F, 1'b1, 4'b0111, 1'b0);

        // Reset at cnt=5 of slot 2 with a load still pending
        runTo(199);
        applyStimulus(16'h9999, 4'b0000, 4'b0000);
        runTo(213); checkOutput("pre_reset_d2", 7'h20, 1'b1, 4'b1011, 1'b0);
        reset = 1'b1;
        step();
        checkOutput("mid_reset",               7'h7F, 1'b1, 4'hF,    1'b0);
        reset = 1'b0;
        cyc   = 0;
`ifdef DISPLAY_BLINK_EN
        blink_mask = 4'b0001;
`endif
        runTo(1);  checkOutput("restart_c1",    7'h01, 1'b1, 4'hF,    1'b0);
        runTo(3);  checkOutput("restart_d0",    7'h01, 1'b1, 4'b1110, 1'b0);
        runTo(32); checkOutput("restart_wrap",  7'h01, 1'b1, 4'b0111, 1'b1);
        runTo(33); checkOutput("pending_lost",  7'h01, 1'b1, 4'hF,    1'b0);
        runTo(35); checkOutput("pending_lost2", 7'h01, 1'b1, 4'b1110, 1'b0);

`ifdef DISPLAY_BLINK_EN
        // Digit 0 blinks: frames 0,1 lit, 2,3 dark, 4 lit again
        runTo(67);  checkOutput("blink_off_f2", 7'h7F, 1'b1, 4'b1110, 1'b0);
        runTo(99);  checkOutput("blink_off_f3", 7'h7F, 1'b1, 4'b1110, 1'b0);
        runTo(131); checkOutput("blink_on_f4",  7'h01, 1'b1, 4'b1110, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
